rr_arb4: RTL
============

# rr_arb4

Four-requester round-robin arbiter with grant locking, for sharing one datapath resource among four clients. The rotating-priority pick is combinational. A pointer register and a small state machine sequence it, so every requester is guaranteed service. Grants are registered and held while the owner keeps its request asserted. An optional hold limit preempts owners that hold the grant too long.

## Interface
- `HOLD_MAX`, default 8: maximum cycles an owner may hold the grant while others wait. Used only when `ARB_HOLD_LIMIT_EN` is defined. Legal range 2..255.
- `clock` input 1: single clock, rising-edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `en` input 1: arbiter enable. Low forces the grant off.
- `req` input 4: request per client. Bit i is client i.
- `gnt` output 4: registered one-hot grant, or all zeros.
- `gnt_valid` output 1: registered, equal to `|gnt`.
- `gnt_id` output 2: registered index of the granted client. Holds its last value when `gnt_valid` is 0.
- `ptr` output 2: current highest-priority index, exposed for debug.

## Operation
- States:
  - IDLE: no owner.
  - GRANT: `gnt` has exactly one bit set, the owner.
- Pick function, combinational: the first set bit of `req & mask`, scanning from index `ptr` upward modulo 4. Result is `winner[1:0]` plus a `found` flag.
  - In IDLE, mask is `4'b1111`.
  - In GRANT, mask clears the owner bit.
- IDLE, `en`=1 and `|req`: next cycle `gnt` = onehot(winner), `gnt_id` = winner, state → GRANT.
- IDLE with `en`=0 or `req`=0: stay in IDLE, `gnt`=0.
- GRANT, `en`=1 and `req[owner]`=1: hold the grant unchanged. Pointer unchanged.
- GRANT, `en`=1 and `req[owner]`=0: release.
  - `ptr` ← owner+1 (mod 4).
  - If another request is pending, the grant goes to the winner picked from owner+1 in the same cycle. This gives a back-to-back handoff with no bubble, and state stays GRANT.
  - Otherwise `gnt` ← 0 and state → IDLE.
- `en`=0 in any state: next cycle `gnt`=0, state → IDLE. `ptr` and `gnt_id` are kept, and the interrupted owner re-arbitrates normally.
- Pointer update: `ptr` changes only on release or preemption. It becomes the released owner + 1. All arithmetic is 2-bit modulo 4.
- Simultaneous release and new request from the same client: that client is not eligible in this cycle and is picked at the earliest next cycle.
- Reset values:
  - `gnt`=4'b0000, `gnt_valid`=0, `gnt_id`=2'b00.
  - `ptr`=2'b00, so initial priority is 0>1>2>3.
  - State IDLE, hold counter 0.
- Reset asserted mid-grant: all of the above apply immediately and asynchronously. The first grant after reset deassertion follows the same one-cycle latency.

## Timing
- Grant latency is one cycle. A `req` sampled at edge k appears on `gnt` after edge k and is visible during cycle k+1.
- Release latency is one cycle. The owner drops `req` before edge k; after edge k, `gnt` moves to the next owner or clears.
- `en` deassertion clears `gnt` after the next edge.
- All outputs are flops. There is no combinational path from input to output.

## Configuration
- `ARB_HOLD_LIMIT_EN` defined:
  - An 8-bit `hold_cnt` counts GRANT cycles, clears on each new grant, and saturates at `HOLD_MAX`.
  - When `hold_cnt` = `HOLD_MAX`−1, `req[owner]`=1 and another client is requesting, the owner is preempted. This is handled exactly as a release: `ptr` ← owner+1 and the grant goes to the next winner.
  - If no other client is requesting, the owner continues holding.
  - The owner therefore holds the grant for at most `HOLD_MAX` consecutive cycles while others wait.
- `ARB_HOLD_LIMIT_EN` undefined: no counter. The owner holds the grant indefinitely while `req[owner]` and `en` stay high.

## Structure
- Package `rr_arb_pkg` contains:
  - `typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t`
  - `localparam N_REQ = 4`
  - `typedef logic [1:0] req_idx_t`
- Sub-module `rr_pick4` is purely combinational. Inputs are `req[3:0]`, `mask[3:0]` and `ptr[1:0]`; outputs are `winner[1:0]` and `found`. It is unit-testable on its own.
- Top-level `rr_arb4` holds the state, pointer, grant and hold-counter registers.

## Test plan
- Reset, then `en`=1 and `req`=4'b1111 → after one edge, `gnt`=4'b0001 and `gnt_id`=0. Client 0 drops its request → next `gnt`=4'b0010, `ptr`=1.
- Round-robin fairness with `req`=4'b1111, each owner dropping its request for one cycle after one held cycle → grant order 0,1,2,3,0. No client is granted twice before all four have been served.
- `req`=4'b0100 only → `gnt`=4'b0100 after one edge. Drop `req` → `gnt`=0, state IDLE, `ptr`=3. Then `req`=4'b0101 → `gnt`=4'b0001.
- While `gnt`=4'b0010, drive `en`=0 → `gnt`=0 after one edge, `ptr` unchanged. Set `en`=1 with `req`=4'b0010 → `gnt`=4'b0010 again.
- Assert `reset_n`=0 asynchronously while `gnt`=4'b1000 → `gnt`=0, `gnt_id`=0 and `ptr`=0 immediately, without waiting for a clock edge.
- With `ARB_HOLD_LIMIT_EN` and `HOLD_MAX`=8: client 1 holds the grant with `req`=4'b0011 → `gnt`=4'b0010 for exactly 8 cycles, then 4'b0001. With `req`=4'b0010 only, client 1 holds beyond 8 cycles.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types for the four-client round-robin arbiter.
// Holds the FSM encoding, client index type and a one-hot helper.
package rr_arb_pkg;

  localparam int N_REQ = 4;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

  typedef logic [1:0] req_idx_t;

  function automatic logic [N_REQ-1:0] onehot(req_idx_t i);
    logic [N_REQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first set bit of req & mask,
// scanning upward from ptr, modulo 4. Purely combinational.
import rr_arb_pkg::*;

module rr_pick4 (
  input  logic [3:0] req,
  input  logic [3:0] mask,
  input  req_idx_t   ptr,
  output req_idx_t   winner,
  output logic       found
);

  logic [3:0] elig;
  logic [3:0] rot;
  req_idx_t   off;

  always_comb begin
    elig = req & mask;
    // rotate so that bit ptr lands at position 0
    rot  = 4'({elig, elig} >> ptr);
    off  = 2'd0;
    priority case (1'b1)
      rot[0]:  off = 2'd0;
      rot[1]:  off = 2'd1;
      rot[2]:  off = 2'd2;
      rot[3]:  off = 2'd3;
      default: off = 2'd0;
    endcase
    found  = |elig;
    winner = req_idx_t'(ptr + off);
  end

endmodule

// File: rtl/rr_arb4.sv
// Four-client round-robin arbiter with registered, locked grants.
// Define ARB_HOLD_LIMIT_EN to preempt owners after HOLD_MAX cycles.
import rr_arb_pkg::*;

module rr_arb4 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic [1:0] gnt_id,
  output logic [1:0] ptr
);

  arb_state_t state_q, state_d;
  req_idx_t   ptr_q, ptr_d;
  req_idx_t   id_q, id_d;
  logic [3:0] gnt_q, gnt_d;
  logic       valid_q, valid_d;

  logic [3:0] pick_mask;
  req_idx_t   pick_ptr;
  req_idx_t   winner;
  logic       found;
  logic       owner_req;
  logic       preempt;
  logic       handoff;

  // In GRANT the owner is masked out and the scan starts past it,
  // so a release can hand off in the same cycle.
  always_comb begin
    if (state_q == ARB_GRANT) begin
      pick_mask = ~onehot(id_q);
      pick_ptr  = req_idx_t'(id_q + 2'd1);
    end else begin
      pick_mask = 4'b1111;
      pick_ptr  = ptr_q;
    end
  end

  rr_pick4 u_pick (
    .req    (req),
    .mask   (pick_mask),
    .ptr    (pick_ptr),
    .winner (winner),
    .found  (found)
  );

  assign owner_req = req[id_q];

`ifdef ARB_HOLD_LIMIT_EN
  logic [7:0] hold_q, hold_d;

  assign preempt = (state_q == ARB_GRANT) && owner_req && found
                && (hold_q == 8'(HOLD_MAX - 1));
`else
  logic unused_hold;

  assign unused_hold = |HOLD_MAX;
  assign preempt     = 1'b0;
`endif

  assign handoff = !owner_req || preempt;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
`ifdef ARB_HOLD_LIMIT_EN
    hold_d  = hold_q;
`endif
    if (!en) begin
      state_d = ARB_IDLE;
      gnt_d   = 4'b0000;
      valid_d = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
      hold_d  = 8'd0;
`endif
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (found) begin
            state_d = ARB_GRANT;
            gnt_d   = onehot(winner);
            id_d    = winner;
            valid_d = 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
            hold_d  = 8'd0;
`endif
          end
        end
        ARB_GRANT: begin
          if (handoff) begin
            ptr_d = req_idx_t'(id_q + 2'd1);
`ifdef ARB_HOLD_LIMIT_EN
            hold_d = 8'd0;
`endif
            if (found) begin
              gnt_d = onehot(winner);
              id_d  = winner;
            end else begin
              state_d = ARB_IDLE;
              gnt_d   = 4'b0000;
              valid_d = 1'b0;
            end
          end
`ifdef ARB_HOLD_LIMIT_EN
          else if (hold_q < 8'(HOLD_MAX)) begin
            hold_d = hold_q + 8'd1;
          end
`endif
        end
        default: begin
          state_d = ARB_IDLE;
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
      ptr_q   <= 2'd0;
      id_q    <= 2'd0;
      gnt_q   <= 4'b0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) hold_q <= 8'd0;
    else          hold_q <= hold_d;
  end
`endif

  assign gnt       = gnt_q;
  assign gnt_valid = valid_q;
  assign gnt_id    = id_q;
  assign ptr       = ptr_q;

endmodule
